// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Reads a burst of consecutive words from a single-port BRAM read port and
// presents them as an AXI-Stream style master. The BRAM address wraps from
// the last word back to 0. A 4-entry output FIFO absorbs back-pressure. Read
// issue is throttled so that the words already in the FIFO plus the reads
// still travelling through the BRAM pipeline never exceed the FIFO depth.
//
// Parameters
//   RAM_WIDTH   data word width
//   RAM_DEPTH   number of BRAM words (address width is fixed at 11 bits)
//   RD_LATENCY  BRAM read latency in cycles, 1 or 2
//
// Ports
//   clka           single clock, rising edge
//   rsta           asynchronous active-high reset
//   start          one-cycle burst request (ignored while busy or len == 0)
//   start_addr     first word address of the burst
//   len            burst length in words, 1..2048
//   busy           high from the cycle after an accepted start until the
//                  last word handshake
//   done           one-cycle pulse in the cycle of the last word handshake
//   bram_en        BRAM read enable
//   bram_addr      BRAM read address
//   bram_dout      BRAM read data, valid RD_LATENCY cycles after bram_en
//   m_axis_tdata   stream data (FIFO head)
//   m_axis_tvalid  stream valid (FIFO not empty)
//   m_axis_tready  stream ready from the sink
//   m_axis_tlast   last word of the burst (only with BRAM_RD_TLAST_EN)
//
// Build option
//   BRAM_RD_TLAST_EN  when defined, adds the m_axis_tlast port and the
//                     output word counter that drives it.
//
// Timing note: the first read is issued combinationally in the start cycle so
// that the first word is valid RD_LATENCY+1 cycles after start. For this
// reason bram_en, bram_addr and done are decoded from registered state plus
// the current-cycle start/handshake; all are forced low while rsta is high.
// -----------------------------------------------------------------------------
module bram_stream_reader #(
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 2048,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 start,
  input  logic [10:0]          start_addr,
  input  logic [11:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic                 bram_en,
  output logic [10:0]          bram_addr,
  input  logic [RAM_WIDTH-1:0] bram_dout,
  output logic [RAM_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
`ifdef BRAM_RD_TLAST_EN
  ,
  output logic                 m_axis_tlast
`endif
);

  localparam int          FIFO_DEPTH = 4;
  localparam logic [10:0] LAST_ADDR  = 11'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Registered state
  state_t               state_r;
  logic                 busy_r;
  logic [10:0]          addr_r;        // next address to issue while in READ
  logic [11:0]          issue_left_r;  // reads still to issue
  logic [RD_LATENCY-1:0] pipe_r;       // one bit per read inside the BRAM pipeline

  logic [RAM_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [1:0]           wr_ptr_r;
  logic [1:0]           rd_ptr_r;
  logic [2:0]           count_r;

  // Decoded per-cycle controls
  logic        accept_s;
  logic        issue_s;
  logic        room_s;
  logic        pop_s;
  logic        wr_s;
  logic        last_pop_s;
  logic [2:0]  in_flight_s;
  logic [10:0] bram_addr_s;

  // Address after a, wrapping at the top of the BRAM.
  function automatic logic [10:0] next_addr(input logic [10:0] a);
    if (a == LAST_ADDR) begin
      return 11'd0;
    end else begin
      return a + 11'd1;
    end
  endfunction

  // Number of reads currently travelling through the BRAM pipeline.
  function automatic logic [2:0] pipe_ones(input logic [RD_LATENCY-1:0] p);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + {2'b00, p[i]};
    end
    return n;
  endfunction

  // Issue / accept / handshake decode.
  always_comb begin
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    last_pop_s  = 1'b0;
    in_flight_s = pipe_ones(pipe_r);
    // Count everything that will eventually occupy a FIFO slot.
    room_s      = (({1'b0, count_r} + {1'b0, in_flight_s}) < 4'd4);
    pop_s       = (count_r != 3'd0) && m_axis_tready;
    wr_s        = pipe_r[RD_LATENCY-1];
    bram_addr_s = addr_r;
    if (rsta) begin
      bram_addr_s = 11'd0;
    end else begin
      case (state_r)
        IDLE: begin
          accept_s = start && (len != 12'd0);
          issue_s  = accept_s;
          if (accept_s) begin
            bram_addr_s = start_addr;
          end else begin
            bram_addr_s = addr_r;
          end
        end
        READ: begin
          issue_s = (issue_left_r != 12'd0) && room_s;
        end
        DRAIN: begin
          // All reads issued: the last word is the sole FIFO entry with
          // nothing left in the BRAM pipeline.
          last_pop_s = pop_s && (count_r == 3'd1) && (in_flight_s == 3'd0);
        end
        default: begin
          issue_s = 1'b0;
        end
      endcase
    end
  end

  // Burst control FSM: state, busy, read address and remaining-read count.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      addr_r       <= 11'd0;
      issue_left_r <= 12'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // The first read goes out in this cycle.
            busy_r       <= 1'b1;
            addr_r       <= next_addr(start_addr);
            issue_left_r <= len - 12'd1;
            state_r      <= (len == 12'd1) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue_s) begin
            addr_r       <= next_addr(addr_r);
            issue_left_r <= issue_left_r - 12'd1;
            if (issue_left_r == 12'd1) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // BRAM pipeline tracker; clearing it on reset discards late read data.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= issue_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; captures BRAM data as each tracked read completes.
  always_ff @(posedge clka) begin
    if (wr_s) begin
      fifo_mem_r[wr_ptr_r] <= bram_dout;
    end
  end

`ifdef BRAM_RD_TLAST_EN
  logic [11:0] out_left_r;  // words still to hand over to the sink

  // Output word counter used to flag the final word of the burst.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      out_left_r <= 12'd0;
    end else if (accept_s) begin
      out_left_r <= len;
    end else if (pop_s && (out_left_r != 12'd0)) begin
      out_left_r <= out_left_r - 12'd1;
    end else begin
      out_left_r <= out_left_r;
    end
  end

  assign m_axis_tlast = (count_r != 3'd0) && (out_left_r == 12'd1);
`endif

  assign busy          = busy_r;
  assign done          = last_pop_s;
  assign bram_en       = issue_s;
  assign bram_addr     = bram_addr_s;
  assign m_axis_tvalid = (count_r != 3'd0);
  assign m_axis_tdata  = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A BRAM model holds mem[i] = i
// with a two-cycle registered read. A negedge monitor records every stream
// handshake, done pulse and read issue; the directed sequence then compares
// those records against the expected word list (start_addr + k modulo 2048)
// and the expected cycle timing.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int LAT = 2;

  logic        clka = 1'b0;
  logic        rsta;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        bram_en;
  logic [10:0] bram_addr;
  logic [15:0] bram_dout;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
`ifdef BRAM_RD_TLAST_EN
  logic        m_axis_tlast;
`endif

  bram_stream_reader #(
    .RAM_WIDTH (16),
    .RAM_DEPTH (2048),
    .RD_LATENCY(LAT)
  ) dut (
    .clka         (clka),
    .rsta         (rsta),
    .start        (start),
    .start_addr   (start_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .bram_en      (bram_en),
    .bram_addr    (bram_addr),
    .bram_dout    (bram_dout),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef BRAM_RD_TLAST_EN
    ,
    .m_axis_tlast (m_axis_tlast)
`endif
  );

  // Clock generation.
  always #5 clka = ~clka;

  // BRAM model: two-cycle registered read.
  logic [15:0] mem [2048];
  logic [15:0] q1;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
  end

  // BRAM read pipeline.
  always @(posedge clka) begin
    if (bram_en) q1 <= mem[bram_addr];
    bram_dout <= q1;
  end

  int cyc = 0;
  // Cycle counter; cycle N is the interval following the posedge that set it.
  always @(posedge clka) cyc <= cyc + 1;

  // Monitor records
  logic [15:0] obs_data [$];
  int          obs_cyc  [$];
`ifdef BRAM_RD_TLAST_EN
  bit          obs_last [$];
`endif
  int          done_cyc [$];
  bit          done_pop [$];
  int          en_total = 0;   // reads issued since last reset
  int          pop_total = 0;  // words popped since last reset
  int          en_over = 0;    // reads issued while 4 words were outstanding
  int          en_all = 0;
  int          busy_cnt = 0;

  // Negedge monitor of handshakes, done pulses and read issue.
  always @(negedge clka) begin
    if (m_axis_tvalid && m_axis_tready) begin
      obs_data.push_back(m_axis_tdata);
      obs_cyc.push_back(cyc);
`ifdef BRAM_RD_TLAST_EN
      obs_last.push_back(m_axis_tlast);
`endif
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_pop.push_back(m_axis_tvalid && m_axis_tready);
    end
    if (bram_en) en_all <= en_all + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (rsta) begin
      en_total  <= 0;
      pop_total <= 0;
    end else begin
      if (bram_en) begin
        en_total <= en_total + 1;
        if ((en_total - pop_total) >= 4) en_over <= en_over + 1;
      end
      if (m_axis_tvalid && m_axis_tready) pop_total <= pop_total + 1;
    end
  end

  int total = 0;
  int bad = 0;
  int s_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input int sa, input int k);
    return 16'((sa + k) % 2048);
  endfunction

  task automatic do_start(input int sa, input int n);
    @(posedge clka); #1;
    start      = 1'b1;
    start_addr = 11'(sa);
    len        = 12'(n);
    s_cyc      = cyc;
    @(posedge clka); #1;
    start      = 1'b0;
  endtask

  // mode 0: tready held 1; mode 1: random tready (75% high)
  task automatic wait_done(input int bd, input int mode, input int limit, input string tag);
    int k;
    k = 0;
    while (done_cyc.size() <= bd && k < limit) begin
      @(posedge clka); #1;
      m_axis_tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      k++;
    end
    check({tag, " done_seen"}, 32'(done_cyc.size() > bd), 32'd1);
    m_axis_tready = 1'b1;
    repeat (4) @(posedge clka);
    #1;
  endtask

  task automatic check_burst(input string tag, input int sa, input int n,
                             input int bo, input int bd, input bit strict);
    int got_n, errs, lim, nd;
    got_n = obs_data.size() - bo;
    nd    = done_cyc.size() - bd;
    check({tag, " count"}, 32'(got_n), 32'(n));
    lim  = (got_n < n) ? got_n : n;
    errs = 0;
    for (int k = 0; k < lim; k++) begin
      if (obs_data[bo+k] !== ref_word(sa, k)) errs++;
    end
    check({tag, " data_errs"}, 32'(errs), 32'd0);
    if (got_n > 0) begin
      check({tag, " first_word"}, 32'(obs_data[bo]), 32'(ref_word(sa, 0)));
      check({tag, " last_word"}, 32'(obs_data[bo+got_n-1]), 32'(ref_word(sa, n-1)));
    end
    check({tag, " done_pulses"}, 32'(nd), 32'd1);
    if (nd > 0 && got_n > 0) begin
      check({tag, " done_cycle"}, 32'(done_cyc[bd]), 32'(obs_cyc[bo+got_n-1]));
      check({tag, " done_with_pop"}, 32'(done_pop[bd]), 32'd1);
    end
    if (strict && got_n > 0) begin
      check({tag, " first_valid_cyc"}, 32'(obs_cyc[bo]), 32'(s_cyc + LAT + 1));
      check({tag, " last_word_cyc"}, 32'(obs_cyc[bo+got_n-1]), 32'(s_cyc + LAT + n));
    end
`ifdef BRAM_RD_TLAST_EN
    errs = 0;
    for (int k = 0; k < lim; k++) begin
      if (obs_last[bo+k] !== (k == n - 1)) errs++;
    end
    check({tag, " tlast_errs"}, 32'(errs), 32'd0);
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed and randomized sequence.
  initial begin
    int bo, bd, sa, n, e0, b0;

    // Reset with a start request present: nothing may leak out.
    rsta = 1'b1; start = 1'b1; start_addr = 11'h123; len = 12'd5; m_axis_tready = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst bram_en", 32'(bram_en), 32'd0);
    check("rst bram_addr", 32'(bram_addr), 32'd0);
    check("rst tvalid", 32'(m_axis_tvalid), 32'd0);
`ifdef BRAM_RD_TLAST_EN
    check("rst tlast", 32'(m_axis_tlast), 32'd0);
`endif
    start = 1'b0;
    @(posedge clka); #1;
    rsta = 1'b0;
    repeat (2) @(posedge clka);
    #1;

    // Basic burst, full throughput
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h010, 8);
    wait_done(bd, 0, 100, "b8");
    check_burst("b8", 12'h010, 8, bo, bd, 1'b1);

    // Address wrap
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h7FE, 4);
    wait_done(bd, 0, 100, "wrap");
    check_burst("wrap", 12'h7FE, 4, bo, bd, 1'b1);

    // Single word
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h045, 1);
    wait_done(bd, 0, 100, "len1");
    check_burst("len1", 12'h045, 1, bo, bd, 1'b1);

    // Back-pressure: toggle then hold tready low for 10 cycles
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h200, 16);
    for (int c = 0; c < 6; c++) begin
      @(posedge clka); #1;
      m_axis_tready = (c % 2 == 0);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clka); #1;
      m_axis_tready = 1'b0;
    end
    @(posedge clka); #1;
    check("stall outstanding", 32'(en_total - pop_total), 32'd4);
    check("stall tvalid", 32'(m_axis_tvalid), 32'd1);
    wait_done(bd, 0, 200, "stall");
    check_burst("stall", 12'h200, 16, bo, bd, 1'b0);

    // Second start while busy is ignored
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h030, 5);
    @(posedge clka); #1;
    @(posedge clka); #1;
    start = 1'b1; start_addr = 11'h400; len = 12'd7;
    @(posedge clka); #1;
    start = 1'b0;
    wait_done(bd, 0, 100, "restart");
    repeat (20) @(posedge clka);
    #1;
    check_burst("restart", 12'h030, 5, bo, bd, 1'b1);
    check("restart idle busy", 32'(busy), 32'd0);

    // Reset mid-burst, one-cycle pulse so late BRAM data returns after it
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h050, 10);
    for (int c = 0; c < 50 && (obs_data.size() - bo) < 3; c++) begin
      @(posedge clka); #1;
    end
    rsta = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort tvalid", 32'(m_axis_tvalid), 32'd0);
    check("abort bram_en", 32'(bram_en), 32'd0);
    @(posedge clka); #1;
    rsta = 1'b0;
    repeat (8) @(posedge clka);
    #1;
    check("abort words", 32'(obs_data.size() - bo), 32'd3);
    check("abort done", 32'(done_cyc.size() - bd), 32'd0);
    check("abort tvalid_after", 32'(m_axis_tvalid), 32'd0);
    if (obs_data.size() - bo >= 3)
      check("abort third_word", 32'(obs_data[bo+2]), 32'h52);
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h100, 2);
    wait_done(bd, 0, 100, "post_rst");
    check_burst("post_rst", 12'h100, 2, bo, bd, 1'b1);

    // len = 0 is ignored
    bo = obs_data.size(); e0 = en_all; b0 = busy_cnt;
    do_start(12'h300, 0);
    repeat (10) @(posedge clka);
    #1;
    check("len0 busy", 32'(busy_cnt - b0), 32'd0);
    check("len0 bram_en", 32'(en_all - e0), 32'd0);
    check("len0 words", 32'(obs_data.size() - bo), 32'd0);

    // Full-depth burst with wrap, full throughput
    bo = obs_data.size(); bd = done_cyc.size();
    do_start(12'h123, 2048);
    wait_done(bd, 0, 2200, "full");
    check_burst("full", 12'h123, 2048, bo, bd, 1'b1);

    // Randomized bursts with random back-pressure
    for (int r = 0; r < 8; r++) begin
      sa = $urandom_range(0, 2047);
      n  = $urandom_range(1, 40);
      bo = obs_data.size(); bd = done_cyc.size();
      do_start(sa, n);
      wait_done(bd, 1, 800, "rand");
      check_burst("rand", sa, n, bo, bd, 1'b0);
    end

    check("never over 4 outstanding", 32'(en_over), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16, meaning the data word width.
REQ-002 SHALL have parameter RAM_DEPTH, default 2048, meaning the number of words; address width is fixed at 11 bits.
REQ-003 SHALL have parameter RD_LATENCY, default 2, meaning the BRAM read latency in cycles; legal values are 1 and 2.
REQ-004 clka  input  1  the single clock; all logic on its rising edge.
REQ-005 rsta  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a burst.
REQ-007 start_addr  input  11  first word address.
REQ-008 len  input  12  burst length in words, 1..2048.
REQ-009 busy  output  1  high from an accepted start until the last word handshakes.
REQ-010 done  output  1  one-cycle pulse on the last word handshake.
REQ-011 bram_en  output  1  BRAM port read enable.
REQ-012 bram_addr  output  11  BRAM port address.
REQ-013 bram_dout  input  RAM_WIDTH  BRAM port read data.
REQ-014 m_axis_tdata  output  RAM_WIDTH  stream data.
REQ-015 m_axis_tvalid  output  1  stream valid.
REQ-016 m_axis_tready  input  1  stream ready from the downstream sink.
REQ-017 m_axis_tlast  output  1  final word of the burst; present only with BRAM_RD_TLAST_EN.

Function
REQ-018 SHALL implement FSM states: IDLE, READ (issuing reads), DRAIN (all reads issued, outputs pending).
REQ-019 IDLE->READ when start=1 and len!=0; start_addr and len are latched; start with len=0 is ignored.
REQ-020 start while busy=1 SHALL be ignored with no effect on the running burst.
REQ-021 In READ, bram_en=1 in a cycle only if words remain to issue and (fifo_count + in_flight) < 4.
REQ-022 bram_addr SHALL increment by 1 per issued read and wrap from 2047 to 0.
REQ-023 Data captured from bram_dout exactly RD_LATENCY cycles after the bram_en cycle SHALL be written into a 4-entry output FIFO.
REQ-024 The FIFO SHALL never overflow, and no word SHALL be dropped or duplicated under any tready pattern.
REQ-025 m_axis_tvalid SHALL equal FIFO not empty; tdata SHALL be the FIFO head; the FIFO pops on tvalid&tready.
REQ-026 With tready held at 1, after the fixed startup latency the stream SHALL sustain 1 word per cycle.
REQ-027 The first tvalid SHALL occur RD_LATENCY+1 cycles after the start cycle.
REQ-028 READ->DRAIN when the last read issues; DRAIN->IDLE on the last word handshake, with done=1 in that cycle.
REQ-029 A start in the same cycle as done is ignored; a new burst requires busy=0 at the start cycle.
REQ-030 Words SHALL be output in address order starting at start_addr, and exactly len words SHALL be output.

Reset
REQ-031 rsta=1 SHALL immediately force IDLE, empty the FIFO, clear in-flight tracking, and drive busy, done, bram_en, m_axis_tvalid and m_axis_tlast to 0 and bram_addr to 0.
REQ-032 Reset during a burst SHALL abort it with no done pulse, and BRAM data returning after reset SHALL be discarded.

Configuration
REQ-033 Macro BRAM_RD_TLAST_EN defined: m_axis_tlast exists and is 1 only on the word numbered len of the burst, qualified by tvalid.
REQ-034 Macro BRAM_RD_TLAST_EN undefined: the m_axis_tlast port and its counter logic are absent, and all other behaviour is identical.

Verification
REQ-035 BRAM model RD_LATENCY=2 with mem[i]=i; start_addr=0x010, len=8, tready=1 -> tdata 0x10..0x17 on consecutive cycles, first tvalid 3 cycles after start, done with word 0x17, tlast with 0x17.
REQ-036 start_addr=0x7FE, len=4 -> tdata 0x7FE, 0x7FF, 0x000, 0x001.
REQ-037 len=16, tready toggling 1/0 and then held 0 for 10 cycles mid-burst -> all 16 words in order, no loss, bram_en stalls once 4 words are outstanding.
REQ-038 start pulsed again 3 cycles after the first start (len=5) -> only 5 words output and a single done pulse.
REQ-039 rsta asserted after 3 words of a len=10 burst, then a new start_addr=0x100, len=2 -> no done for the aborted burst; output is exactly 0x100 and 0x101.
REQ-040 start with len=0 -> busy remains 0, bram_en never asserts, and no output words.
